// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: pending-write record and x0 constant.
package rf_arb_pkg;

  localparam int RF_DATA_W = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [4:0]           rd;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Pending long-latency results; push visible at head the cycle after the edge, no fall-through.
// Per-entry valid/rd vectors let the parent flag hazards against every queued destination.
module rf_wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  rf_wr_t                     push_dat,
  input  logic                       pop,
  output rf_wr_t                     head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DEPTH-1:0]           ent_vld,
  output logic [DEPTH-1:0][4:0]      ent_rd
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  rf_wr_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem[i].rd;
    end
  end

  // Payload needs no reset: ent_vld gates every use of a slot.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (do_push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        ent_vld[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        ent_vld[rd_ptr] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RegFile write port: W stage always wins, queued unit results drain into idle slots.
// Unit results write no earlier than the cycle after acceptance; lu_ready drops only when the queue is full.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RegWriteW,
  input  logic [4:0]               RdW,
  input  logic [DATA_WIDTH-1:0]    ResultW,
  input  logic                     lu_valid,
  input  logic [4:0]               lu_rd,
  input  logic [DATA_WIDTH-1:0]    lu_data,
  output logic                     lu_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_addr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  input  logic [4:0]               Rs1D,
  input  logic [4:0]               Rs2D,
  input  logic [4:0]               RdD,
  output logic                     busy_rs1,
  output logic                     busy_rs2,
  output logic                     busy_rd,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  rf_wr_t                  push_dat;
  rf_wr_t                  head;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    w_own;
  logic                    we_int;
  logic [DEPTH-1:0]        ent_vld;
  logic [DEPTH-1:0][4:0]   ent_rd;
  logic [WW-1:0]           wait_cnt;
  logic [WW-1:0]           wait_nxt;

  assign w_own         = RegWriteW && (RdW != REG_X0);
  assign pop           = !w_own && !empty;
  assign lu_ready      = !full;
  // x0 results are acknowledged but never stored.
  assign push          = lu_valid && lu_ready && (lu_rd != REG_X0);
  assign push_dat.rd   = lu_rd;
  assign push_dat.data = lu_data;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (pending),
    .ent_vld  (ent_vld),
    .ent_rd   (ent_rd)
  );

  always_comb begin
    we_int   = 1'b0;
    rf_addr  = REG_X0;
    rf_wdata = '0;
    if (w_own) begin
      we_int   = 1'b1;
      rf_addr  = RdW;
      rf_wdata = ResultW;
    end else if (!empty) begin
      we_int   = 1'b1;
      rf_addr  = head.rd;
      rf_wdata = head.data;
    end
  end

  assign rf_we = we_int && rst_n;

  // Non-empty without a pop means W held the port this cycle.
  always_comb begin
    wait_nxt = wait_cnt;
    if (empty || pop) begin
      wait_nxt = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_nxt = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      stall_req <= 1'b0;
    end else begin
      wait_cnt  <= wait_nxt;
      stall_req <= (wait_nxt == WAIT_MAX);
    end
  end

  always_comb begin
    busy_rs1 = 1'b0;
    busy_rs2 = 1'b0;
    busy_rd  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) begin
        if ((Rs1D != REG_X0) && (ent_rd[i] == Rs1D)) busy_rs1 = 1'b1;
        if ((Rs2D != REG_X0) && (ent_rd[i] == Rs2D)) busy_rs2 = 1'b1;
        if ((RdD  != REG_X0) && (ent_rd[i] == RdD))  busy_rd  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_rf_write_arbiter;

  localparam int DW       = 32;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic          clk;
  logic          rst_n;
  logic          RegWriteW;
  logic [4:0]    RdW;
  logic [DW-1:0] ResultW;
  logic          lu_valid;
  logic [4:0]    lu_rd;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          rf_we;
  logic [4:0]    rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [4:0]    Rs1D;
  logic [4:0]    Rs2D;
  logic [4:0]    RdD;
  logic          busy_rs1;
  logic          busy_rs2;
  logic          busy_rd;
  logic          stall_req;
  logic [$clog2(DEPTH):0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  int   m_wait;
  bit   m_stall;

  rf_write_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_rd(busy_rd),
    .stall_req(stall_req), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_wown();
    return RegWriteW && (RdW != 5'd0);
  endfunction

  function automatic bit m_we();
    return rst_n && (m_wown() || q.size() > 0);
  endfunction

  function automatic logic [4:0] m_addr();
    if (m_wown()) return RdW;
    if (q.size() > 0) return q[0].rd;
    return 5'd0;
  endfunction

  function automatic logic [DW-1:0] m_wdata();
    if (m_wown()) return ResultW;
    if (q.size() > 0) return q[0].data;
    return '0;
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    q.delete();
    m_wait  = 0;
    m_stall = 1'b0;
  endtask

  // Advance one clock edge, applying the arbitration rules to the model; returns at edge+1.
  task automatic tick();
    bit   pop_m;
    bit   push_m;
    bit   was_empty;
    ent_t e;
    pop_m     = !m_wown() && q.size() > 0;
    push_m    = lu_valid && (q.size() < DEPTH) && (lu_rd != 5'd0);
    was_empty = (q.size() == 0);
    e.rd      = lu_rd;
    e.data    = lu_data;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(e);
      if (was_empty || pop_m) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
      m_stall = (m_wait == MAX_WAIT);
    end
    #1;
  endtask

  task automatic drive(input bit w, input logic [4:0] rdw, input logic [DW-1:0] res,
                       input bit lv, input logic [4:0] lrd, input logic [DW-1:0] ldat);
    RegWriteW = w;
    RdW       = rdw;
    ResultW   = res;
    lu_valid  = lv;
    lu_rd     = lrd;
    lu_data   = ldat;
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0;
    model_clear();
    drive(1'b1, 5'd4, 32'hdead_beef, 1'b0, 5'd0, '0);
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
    tick(); tick();
    checks++;
    if (pending !== 2'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    checks++;
    if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    checks++;
    if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", lu_ready); end
    rst_n = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick();
  endtask

  task automatic test_single_drain();
    drive(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'h1234);
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL single_nobypass got=%0b exp=0", rf_we); end
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    checks++;
    if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL single_write got=%0b/%0d/%h exp=1/5/1234", rf_we, rf_addr, rf_wdata);
    end
    checks++;
    if (pending !== 2'd1) begin errors++; $display("FAIL single_pend1 got=%0d exp=1", pending); end
    tick();
    checks++;
    if (pending !== 2'd0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL single_pend0 got=%0d/%0b exp=0/0", pending, rf_we);
    end
  endtask

  task automatic test_starvation();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd6, 32'h66);
    tick();
    for (int c = 1; c <= 6; c++) begin
      drive(1'b1, 5'd3, 32'h33 + c, 1'b0, 5'd0, '0);
      checks++;
      if (stall_req !== (c >= 5)) begin
        errors++; $display("FAIL starve_stall cyc=%0d got=%0b exp=%0b", c, stall_req, (c >= 5));
      end
      checks++;
      if (rf_addr !== 5'd3) begin errors++; $display("FAIL starve_wwins cyc=%0d got=%0d exp=3", c, rf_addr); end
      tick();
    end
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    checks++;
    if ({rf_we, rf_addr, rf_wdata, stall_req} !== {1'b1, 5'd6, 32'h66, 1'b1}) begin
      errors++; $display("FAIL starve_drain got=%0b/%0d/%h/%0b exp=1/6/66/1", rf_we, rf_addr, rf_wdata, stall_req);
    end
    tick();
    checks++;
    if (stall_req !== 1'b0 || pending !== 2'd0) begin
      errors++; $display("FAIL starve_release got=%0b/%0d exp=0/0", stall_req, pending);
    end
  endtask

  task automatic test_fill_wrap();
    for (int r = 0; r < 3; r++) begin
      logic [4:0] base;
      base = 5'(10 + 3 * r);
      drive(1'b1, 5'd3, '0, 1'b1, base, 32'h100 + r);
      tick();
      drive(1'b1, 5'd3, '0, 1'b1, base + 5'd1, 32'h200 + r);
      tick();
      drive(1'b1, 5'd3, '0, 1'b1, base + 5'd2, 32'h300 + r);
      checks++;
      if (lu_ready !== 1'b0 || pending !== 2'd2) begin
        errors++; $display("FAIL fill_full rnd=%0d got=%0b/%0d exp=0/2", r, lu_ready, pending);
      end
      tick();
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      checks++;
      if (rf_addr !== base || rf_wdata !== 32'h100 + r) begin
        errors++; $display("FAIL fill_first rnd=%0d got=%0d/%h exp=%0d/%h", r, rf_addr, rf_wdata, base, 32'h100 + r);
      end
      tick();
      checks++;
      if (rf_addr !== base + 5'd1 || rf_wdata !== 32'h200 + r) begin
        errors++; $display("FAIL fill_second rnd=%0d got=%0d/%h exp=%0d/%h", r, rf_addr, rf_wdata, base + 5'd1, 32'h200 + r);
      end
      tick();
      checks++;
      if (rf_we !== 1'b0 || pending !== 2'd0) begin
        errors++; $display("FAIL fill_dropfull rnd=%0d got=%0b/%0d exp=0/0", r, rf_we, pending);
      end
    end
  endtask

  task automatic test_x0();
    drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hffff);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    checks++;
    if (pending !== 2'd0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL x0_push got=%0d/%0b exp=0/0", pending, rf_we);
    end
    drive(1'b1, 5'd3, '0, 1'b1, 5'd9, 32'h99);
    tick();
    drive(1'b1, 5'd0, 32'hbad, 1'b0, 5'd0, '0);
    checks++;
    if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin
      errors++; $display("FAIL x0_wb got=%0b/%0d/%h exp=1/9/99", rf_we, rf_addr, rf_wdata);
    end
    tick();
    checks++;
    if (pending !== 2'd0) begin errors++; $display("FAIL x0_drained got=%0d exp=0", pending); end
  endtask

  task automatic test_busy();
    drive(1'b1, 5'd3, '0, 1'b1, 5'd7, 32'h77);
    tick();
    Rs1D = 5'd7; Rs2D = 5'd0; RdD = 5'd7;
    drive(1'b1, 5'd3, '0, 1'b0, 5'd0, '0);
    checks++;
    if ({busy_rs1, busy_rs2, busy_rd} !== 3'b101) begin
      errors++; $display("FAIL busy_set got=%b exp=101", {busy_rs1, busy_rs2, busy_rd});
    end
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    checks++;
    if ({busy_rs1, busy_rd, rf_we, rf_addr} !== {1'b1, 1'b1, 1'b1, 5'd7}) begin
      errors++; $display("FAIL busy_popcycle got=%0b%0b/%0b/%0d exp=11/1/7", busy_rs1, busy_rd, rf_we, rf_addr);
    end
    tick();
    checks++;
    if ({busy_rs1, busy_rs2, busy_rd} !== 3'b000) begin
      errors++; $display("FAIL busy_clear got=%b exp=000", {busy_rs1, busy_rs2, busy_rd});
    end
    Rs1D = 5'd0; RdD = 5'd0;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd3, '0, 1'b1, 5'd20, 32'h20);
    tick();
    drive(1'b1, 5'd3, '0, 1'b1, 5'd21, 32'h21);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 5'd3, '0, 1'b0, 5'd0, '0);
      tick();
    end
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    checks++;
    if (rf_we !== 1'b1 || pending !== 2'd2 || stall_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got=%0b/%0d/%0b exp=1/2/1", rf_we, pending, stall_req);
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got=%0b exp=0", rf_we); end
    tick();
    rst_n = 1'b1;
    #2;
    checks++;
    if (pending !== 2'd0 || stall_req !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_post got=%0d/%0b/%0b exp=0/0/0", pending, stall_req, rf_we);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_stale got=%0b exp=0", rf_we); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      Rs1D = 5'($urandom_range(0, 7));
      Rs2D = 5'($urandom_range(0, 7));
      RdD  = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      checks++;
      if (rf_we !== m_we() || rf_addr !== m_addr() || rf_wdata !== m_wdata()) begin
        errors++;
        $display("FAIL rand_port cyc=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", c, rf_we, rf_addr, rf_wdata, m_we(), m_addr(), m_wdata());
      end
      checks++;
      if (lu_ready !== (q.size() < DEPTH) || pending !== q.size() || stall_req !== m_stall) begin
        errors++;
        $display("FAIL rand_ctrl cyc=%0d got=%0b/%0d/%0b exp=%0b/%0d/%0b", c, lu_ready, pending, stall_req, (q.size() < DEPTH), q.size(), m_stall);
      end
      checks++;
      if ({busy_rs1, busy_rs2, busy_rd} !== {m_busy(Rs1D), m_busy(Rs2D), m_busy(RdD)}) begin
        errors++;
        $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, {busy_rs1, busy_rs2, busy_rd}, {m_busy(Rs1D), m_busy(Rs2D), m_busy(RdD)});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_starvation();
    test_fill_wrap();
    test_x0();
    test_busy();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
